hid_key_event_fifo: RTL and testbench
=====================================

Name: hid_key_event_fifo

Overview:
- Downstream of the keyboard sniffer. Consumes the 8-byte HID boot-keyboard reports that the sniffer extracts from USB DATA packets.
- Diffs each report against the previous one and emits discrete press/release events, each with an ASCII translation.
- Buffers events in a FIFO for the 7-seg/debug display or a later UART stage.

Parameters:
- FIFO_DEPTH, 16, event FIFO entries; power of two, minimum 4.
- AW, 4, FIFO pointer width; equals log2(FIFO_DEPTH).

Ports:
- iCLK  in  1  system clock (50 MHz).
- iRSTN  in  1  asynchronous, active-low reset.
- iREPORT  in  64  HID report. Byte0 = [7:0] modifiers, byte1 = [15:8] reserved, bytes2..7 = [63:16] keycodes K0..K5, K0 at [23:16].
- iREPORT_VALID  in  1  single-cycle strobe; iREPORT is valid in that cycle.
- oBUSY  out  1  high while a report is being scanned.
- oVALID  out  1  FIFO head event is valid.
- iREADY  in  1  consumer accepts the head when oVALID && iREADY.
- oKEYCODE  out  8  head event HID usage code.
- oASCII  out  8  head event ASCII; 0x00 if the code has no mapping.
- oPRESS  out  1  1 = press, 0 = release.
- oMOD  out  8  modifier byte of the report that produced the head event.
- oCOUNT  out  AW+1  FIFO occupancy.
- oOVF  out  1  sticky: an event was lost to a full FIFO.
- oDROPS  out  8  saturating count of reports dropped while busy.

Behaviour:
- Reset (async, iRSTN low):
  - All outputs 0.
  - FIFO empty; previous-report register cleared to all-zero keys.
  - FSM in IDLE.
- FSM states: IDLE, PRESS_SCAN, REL_SCAN, COMMIT.
  - IDLE: on iREPORT_VALID, latch iREPORT into CUR, clear slot index i to 0, go to PRESS_SCAN. oBUSY rises the next cycle.
  - PRESS_SCAN, one slot per cycle, i = 0..5: push {CUR.Ki, press} if CUR.Ki >= 0x04 and CUR.Ki matches none of PREV.K0..K5. At i = 5 reset i and go to REL_SCAN.
  - REL_SCAN, i = 0..5: push {PREV.Ki, release} if PREV.Ki >= 0x04 and PREV.Ki matches none of CUR.K0..K5. At i = 5 go to COMMIT.
  - COMMIT: PREV <= CUR, go to IDLE.
  - A report costs exactly 14 cycles from strobe to return to IDLE.
- Rollover: if CUR.K0..K5 all equal 0x01 (ErrorRollOver), go directly from PRESS_SCAN entry to IDLE. No events are pushed and PREV is unchanged.
- Duplicate codes within one report: each slot is evaluated independently, so duplicates produce duplicate events. This is accepted behaviour.
- Codes 0x00..0x03 never generate events.
- iREPORT_VALID while oBUSY: the report is discarded and oDROPS increments, saturating at 0xFF. A strobe in the COMMIT cycle is also dropped.
- ASCII map, combinational from code plus shift (shift = MOD[1] | MOD[5]):
  - 0x04..0x1D → 'a'..'z', or 'A'..'Z' when shifted.
  - 0x1E..0x26 → '1'..'9'; 0x27 → '0'. Shift does not affect digits.
  - 0x28 → 0x0D; 0x2A → 0x08; 0x2B → 0x09; 0x2C → 0x20.
  - All other codes → 0x00.
  - The ASCII value is computed at push time and stored in the FIFO.
- FIFO:
  - Entry = {keycode, ascii, press, mod}, 25 bits.
  - First-word fall-through: oVALID = (count != 0), head fields driven from the read pointer.
  - Push and pop in the same cycle: count unchanged; valid even when full or empty-with-push. Empty+push+pop: the popped item is the old head, so pop is ignored because oVALID = 0.
  - Push when full with no simultaneous pop: entry dropped, oOVF set. oOVF clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH; count is AW+1 bits, range 0..FIFO_DEPTH.
- Reset mid-scan: FSM aborts, FIFO is flushed, PREV is cleared.

Test Plan:
- Press 'a', shift held: report MOD=0x02, K0=0x04, rest 0 → one event {0x04, 'A'(0x41), press=1, mod=0x02}; oCOUNT=1; oBUSY high for 13 cycles.
- Release then rollover: after the previous report, send an all-zero report → one release {0x04, 0x61, press=0}. Then send K0..K5 = 0x01 → no events and PREV unchanged. Next all-zero report → no events.
- Multi-key diff: PREV = {0x1E, 0x2C}, CUR = {0x2C, 0x27} → FIFO order: press 0x27 ('0'), then release 0x1E ('1'); 0x2C generates nothing.
- Back-to-back: second iREPORT_VALID 5 cycles after the first → second report ignored, oDROPS=1, only the first report's events appear.
- Overflow: hold iREADY=0 with FIFO_DEPTH=16, feed reports producing 18 events → oCOUNT=16, oOVF=1. Then drain with iREADY=1 → 16 events in push order, oVALID falls after the last.
- Simultaneous push/pop at full, plus mid-scan reset: with iREADY=1 at full during a scan, oCOUNT stays 16 and oOVF does not set. Assert iRSTN low mid-PRESS_SCAN → all outputs 0, oCOUNT=0.

Source files
------------

// File: rtl/hid_key_event_fifo.sv
// HID boot-keyboard report differ: compares each 8-byte report against the previous one
// and queues press/release events (keycode, ASCII, direction, modifiers) in a fall-through FIFO.
module hid_key_event_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 4
) (
    input  logic          iCLK,
    input  logic          iRSTN,
    input  logic [63:0]   iREPORT,
    input  logic          iREPORT_VALID,
    output logic          oBUSY,
    output logic          oVALID,
    input  logic          iREADY,
    output logic [7:0]    oKEYCODE,
    output logic [7:0]    oASCII,
    output logic          oPRESS,
    output logic [7:0]    oMOD,
    output logic [AW:0]   oCOUNT,
    output logic          oOVF,
    output logic [7:0]    oDROPS
);

    typedef enum logic [1:0] {IDLE, PRESS_SCAN, REL_SCAN, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       cur_mod_q, cur_mod_d;
    logic [47:0]      cur_keys_q, cur_keys_d;
    logic [47:0]      prev_keys_q, prev_keys_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drops_q, drops_d;
    logic [24:0]      mem_q [FIFO_DEPTH];

    logic [7:0]       scan_key;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             full;
    logic [24:0]      push_data;
    logic [24:0]      head;
    logic             unused_reserved;

    // The reserved report byte carries no information for the differ.
    assign unused_reserved = ^iREPORT[15:8];

    function automatic logic [7:0] hid_to_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] a;
        a = 8'h00;
        if (code >= 8'h04 && code <= 8'h1D) begin
            a = (shift ? 8'h41 : 8'h61) + (code - 8'h04);
        end else if (code >= 8'h1E && code <= 8'h26) begin
            a = 8'h31 + (code - 8'h1E);
        end else begin
            case (code)
                8'h27:   a = 8'h30;
                8'h28:   a = 8'h0D;
                8'h2A:   a = 8'h08;
                8'h2B:   a = 8'h09;
                8'h2C:   a = 8'h20;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

    function automatic logic key_in(input logic [47:0] keys, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int s = 0; s < 6; s++) begin
            if (keys[8*s +: 8] == code) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        scan_key = 8'h00;
        for (int s = 0; s < 6; s++) begin
            if (idx_q == 3'(s)) begin
                scan_key = (state_q == PRESS_SCAN) ? cur_keys_q[8*s +: 8] : prev_keys_q[8*s +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cur_mod_d   = cur_mod_q;
        cur_keys_d  = cur_keys_q;
        prev_keys_d = prev_keys_q;
        push_req    = 1'b0;
        case (state_q)
            IDLE: begin
                if (iREPORT_VALID) begin
                    cur_mod_d  = iREPORT[7:0];
                    cur_keys_d = iREPORT[63:16];
                    idx_d      = 3'd0;
                    state_d    = PRESS_SCAN;
                end
            end
            PRESS_SCAN: begin
                // A full-ErrorRollOver report carries no usable key state; leave PREV alone.
                if (idx_q == 3'd0 && cur_keys_q == {6{8'h01}}) begin
                    state_d = IDLE;
                end else begin
                    push_req = (scan_key >= 8'h04) && !key_in(prev_keys_q, scan_key);
                    if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        state_d = REL_SCAN;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            REL_SCAN: begin
                push_req = (scan_key >= 8'h04) && !key_in(cur_keys_q, scan_key);
                if (idx_q == 3'd5) begin
                    idx_d   = 3'd0;
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            COMMIT: begin
                prev_keys_d = cur_keys_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        push_data = {scan_key, hid_to_ascii(scan_key, cur_mod_q[1] | cur_mod_q[5]),
                     state_q == PRESS_SCAN, cur_mod_q};
        full      = (count_q == (AW+1)'(FIFO_DEPTH));
        pop       = (count_q != '0) && iREADY;
        push_ok   = push_req && (!full || pop);
        wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push_ok && !pop) count_d = count_q + (AW+1)'(1);
        if (!push_ok && pop) count_d = count_q - (AW+1)'(1);
        ovf_d     = ovf_q | (push_req && !push_ok);
        drops_d   = drops_q;
        if (iREPORT_VALID && state_q != IDLE && drops_q != 8'hFF) drops_d = drops_q + 8'd1;
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            cur_mod_q   <= 8'h00;
            cur_keys_q  <= 48'h0;
            prev_keys_q <= 48'h0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            drops_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cur_mod_q   <= cur_mod_d;
            cur_keys_q  <= cur_keys_d;
            prev_keys_q <= prev_keys_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            drops_q     <= drops_d;
        end
    end

    // Storage needs no reset: head fields are masked whenever the FIFO is empty.
    always_ff @(posedge iCLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head     = mem_q[rd_ptr_q];
    assign oVALID   = (count_q != '0);
    assign oKEYCODE = oVALID ? head[24:17] : 8'h00;
    assign oASCII   = oVALID ? head[16:9]  : 8'h00;
    assign oPRESS   = oVALID ? head[8]     : 1'b0;
    assign oMOD     = oVALID ? head[7:0]   : 8'h00;
    assign oBUSY    = (state_q != IDLE);
    assign oCOUNT   = count_q;
    assign oOVF     = ovf_q;
    assign oDROPS   = drops_q;

endmodule

// File: tb/tb_hid_key_event_fifo.sv
// Directed bench for hid_key_event_fifo: report diffing, rollover, drops, overflow and resets.
module tb_hid_key_event_fifo;

    logic        iCLK = 1'b0;
    logic        iRSTN = 1'b0;
    logic [63:0] iREPORT = 64'h0;
    logic        iREPORT_VALID = 1'b0;
    logic        iREADY = 1'b0;
    logic        oBUSY, oVALID, oPRESS, oOVF;
    logic [7:0]  oKEYCODE, oASCII, oMOD, oDROPS;
    logic [4:0]  oCOUNT;

    int checks = 0;
    int passes = 0;

    hid_key_event_fifo #(.FIFO_DEPTH(16), .AW(4)) dut (
        .iCLK(iCLK), .iRSTN(iRSTN), .iREPORT(iREPORT), .iREPORT_VALID(iREPORT_VALID),
        .oBUSY(oBUSY), .oVALID(oVALID), .iREADY(iREADY), .oKEYCODE(oKEYCODE),
        .oASCII(oASCII), .oPRESS(oPRESS), .oMOD(oMOD), .oCOUNT(oCOUNT),
        .oOVF(oOVF), .oDROPS(oDROPS)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Strobe one report and wait for the scan to finish; returns cycles oBUSY was high.
    task automatic send_report(input logic [63:0] r, output int busy);
        iREPORT = r;
        iREPORT_VALID = 1'b1;
        tick();
        iREPORT_VALID = 1'b0;
        busy = 0;
        while (oBUSY && busy < 40) begin
            busy++;
            tick();
        end
    endtask

    task automatic pop_one();
        iREADY = 1'b1;
        tick();
        iREADY = 1'b0;
    endtask

    task automatic test_reset();
        iRSTN = 1'b0;
        repeat (2) tick();
        checks++;
        if ({oBUSY, oVALID, oKEYCODE, oASCII, oPRESS, oMOD, oCOUNT, oOVF, oDROPS} !== 41'h0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {oBUSY, oVALID, oKEYCODE, oASCII, oPRESS, oMOD, oCOUNT, oOVF, oDROPS});
        else passes++;
        iRSTN = 1'b1;
        tick();
    endtask

    task automatic test_press_shift();
        int busy;
        send_report(64'h0000_0000_0004_0002, busy);
        checks++;
        if (busy !== 13) $display("FAIL busy_cycles: got %0d expected 13", busy); else passes++;
        checks++;
        if (oCOUNT !== 5'd1) $display("FAIL press_count: got %0d expected 1", oCOUNT); else passes++;
        checks++;
        if ({oVALID, oKEYCODE, oASCII, oPRESS, oMOD} !== {1'b1, 8'h04, 8'h41, 1'b1, 8'h02})
            $display("FAIL press_shift_a: got %h expected %h",
                     {oVALID, oKEYCODE, oASCII, oPRESS, oMOD}, {1'b1, 8'h04, 8'h41, 1'b1, 8'h02});
        else passes++;
        pop_one();
        checks++;
        if (oCOUNT !== 5'd0) $display("FAIL pop_count: got %0d expected 0", oCOUNT); else passes++;
    endtask

    task automatic test_release_rollover();
        int busy;
        send_report(64'h0, busy);
        checks++;
        if ({oCOUNT, oVALID, oKEYCODE, oASCII, oPRESS, oMOD} !== {5'd1, 1'b1, 8'h04, 8'h61, 1'b0, 8'h00})
            $display("FAIL release_a: got %h expected %h", {oCOUNT, oVALID, oKEYCODE, oASCII, oPRESS, oMOD},
                     {5'd1, 1'b1, 8'h04, 8'h61, 1'b0, 8'h00});
        else passes++;
        pop_one();
        send_report(64'h0101_0101_0101_0000, busy);
        checks++;
        if (busy !== 1) $display("FAIL rollover_busy: got %0d expected 1", busy); else passes++;
        checks++;
        if (oCOUNT !== 5'd0) $display("FAIL rollover_count: got %0d expected 0", oCOUNT); else passes++;
        send_report(64'h0, busy);
        checks++;
        if (oCOUNT !== 5'd0) $display("FAIL zero_after_rollover: got %0d expected 0", oCOUNT); else passes++;
        // Hold 'b', roll over, hold 'b' again: PREV must still contain 0x05.
        send_report(64'h0000_0000_0005_0000, busy);
        checks++;
        if ({oCOUNT, oKEYCODE, oASCII, oPRESS} !== {5'd1, 8'h05, 8'h62, 1'b1})
            $display("FAIL press_b: got %h expected %h", {oCOUNT, oKEYCODE, oASCII, oPRESS},
                     {5'd1, 8'h05, 8'h62, 1'b1});
        else passes++;
        pop_one();
        send_report(64'h0101_0101_0101_0000, busy);
        send_report(64'h0000_0000_0005_0000, busy);
        checks++;
        if (oCOUNT !== 5'd0) $display("FAIL prev_kept_on_rollover: got %0d expected 0", oCOUNT); else passes++;
    endtask

    task automatic test_multi_key();
        int busy;
        send_report(64'h0000_0000_2C1E_0000, busy);
        checks++;
        if (oCOUNT !== 5'd3) $display("FAIL setup_count: got %0d expected 3", oCOUNT); else passes++;
        repeat (3) pop_one();
        send_report(64'h0000_0000_272C_0000, busy);
        checks++;
        if (oCOUNT !== 5'd2) $display("FAIL diff_count: got %0d expected 2", oCOUNT); else passes++;
        checks++;
        if ({oKEYCODE, oASCII, oPRESS} !== {8'h27, 8'h30, 1'b1})
            $display("FAIL diff_first: got %h expected %h", {oKEYCODE, oASCII, oPRESS}, {8'h27, 8'h30, 1'b1});
        else passes++;
        pop_one();
        checks++;
        if ({oKEYCODE, oASCII, oPRESS} !== {8'h1E, 8'h31, 1'b0})
            $display("FAIL diff_second: got %h expected %h", {oKEYCODE, oASCII, oPRESS}, {8'h1E, 8'h31, 1'b0});
        else passes++;
        pop_one();
        checks++;
        if (oVALID !== 1'b0) $display("FAIL diff_empty: got %b expected 0", oVALID); else passes++;
    endtask

    task automatic test_back_to_back();
        int n;
        iREPORT = 64'h0;
        iREPORT_VALID = 1'b1;
        tick();
        iREPORT_VALID = 1'b0;
        repeat (4) tick();
        iREPORT = 64'h0000_0000_0004_0000;
        iREPORT_VALID = 1'b1;
        tick();
        iREPORT_VALID = 1'b0;
        n = 0;
        while (oBUSY && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (oBUSY !== 1'b0) $display("FAIL b2b_idle: got busy %b expected 0", oBUSY); else passes++;
        checks++;
        if (oDROPS !== 8'd1) $display("FAIL b2b_drops: got %0d expected 1", oDROPS); else passes++;
        checks++;
        if ({oCOUNT, oKEYCODE, oASCII, oPRESS} !== {5'd2, 8'h2C, 8'h20, 1'b0})
            $display("FAIL b2b_first: got %h expected %h", {oCOUNT, oKEYCODE, oASCII, oPRESS},
                     {5'd2, 8'h2C, 8'h20, 1'b0});
        else passes++;
        pop_one();
        checks++;
        if ({oKEYCODE, oASCII, oPRESS} !== {8'h27, 8'h30, 1'b0})
            $display("FAIL b2b_second: got %h expected %h", {oKEYCODE, oASCII, oPRESS}, {8'h27, 8'h30, 1'b0});
        else passes++;
        pop_one();
    endtask

    task automatic test_overflow();
        int busy;
        logic [7:0] kc;
        logic       pr;
        send_report(64'h0908_0706_0504_0000, busy);
        send_report(64'h0F0E_0D0C_0B0A_0000, busy);
        checks++;
        if ({oCOUNT, oOVF} !== {5'd16, 1'b1})
            $display("FAIL ovf_full: got count %0d ovf %b expected 16 1", oCOUNT, oOVF);
        else passes++;
        for (int n = 0; n < 16; n++) begin
            kc = (n < 12) ? 8'(4 + n) : 8'(n - 8);
            pr = (n < 12);
            checks++;
            if ({oVALID, oKEYCODE, oASCII, oPRESS, oMOD} !== {1'b1, kc, kc + 8'h5D, pr, 8'h00})
                $display("FAIL drain_%0d: got %h expected %h", n, {oVALID, oKEYCODE, oASCII, oPRESS, oMOD},
                         {1'b1, kc, kc + 8'h5D, pr, 8'h00});
            else passes++;
            pop_one();
        end
        checks++;
        if (oVALID !== 1'b0) $display("FAIL drain_empty: got %b expected 0", oVALID); else passes++;
    endtask

    task automatic test_mid_scan_reset();
        int busy;
        iREPORT = 64'h0000_0000_0004_0000;
        iREPORT_VALID = 1'b1;
        tick();
        iREPORT_VALID = 1'b0;
        repeat (2) tick();
        checks++;
        if ({oBUSY, oVALID} !== 2'b11) $display("FAIL pre_reset_state: got %b expected 11", {oBUSY, oVALID});
        else passes++;
        iRSTN = 1'b0;
        #1;
        checks++;
        if ({oBUSY, oVALID, oKEYCODE, oASCII, oPRESS, oMOD, oCOUNT, oOVF, oDROPS} !== 41'h0)
            $display("FAIL mid_scan_reset: got %h expected 0",
                     {oBUSY, oVALID, oKEYCODE, oASCII, oPRESS, oMOD, oCOUNT, oOVF, oDROPS});
        else passes++;
        tick();
        iRSTN = 1'b1;
        tick();
        send_report(64'h0000_0000_000A_0000, busy);
        checks++;
        if ({oCOUNT, oKEYCODE, oASCII, oPRESS} !== {5'd1, 8'h0A, 8'h67, 1'b1})
            $display("FAIL prev_cleared: got %h expected %h", {oCOUNT, oKEYCODE, oASCII, oPRESS},
                     {5'd1, 8'h0A, 8'h67, 1'b1});
        else passes++;
        pop_one();
    endtask

    task automatic test_full_push_pop();
        int busy;
        int n;
        iRSTN = 1'b0;
        tick();
        iRSTN = 1'b1;
        tick();
        send_report(64'h0908_0706_0504_0000, busy);
        send_report(64'h0, busy);
        send_report(64'h0000_0706_0504_0000, busy);
        checks++;
        if ({oCOUNT, oOVF} !== {5'd16, 1'b0})
            $display("FAIL fill_exact: got count %0d ovf %b expected 16 0", oCOUNT, oOVF);
        else passes++;
        // Pushes land on the ten edges after the strobe; pop on exactly those edges.
        iREPORT = 64'h0D0C_0B0A_0908_0000;
        iREPORT_VALID = 1'b1;
        tick();
        iREPORT_VALID = 1'b0;
        iREADY = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (oCOUNT !== 5'd16) $display("FAIL full_pushpop_%0d: got %0d expected 16", k, oCOUNT);
            else passes++;
        end
        iREADY = 1'b0;
        n = 0;
        while (oBUSY && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if ({oBUSY, oOVF, oCOUNT} !== {1'b0, 1'b0, 5'd16})
            $display("FAIL full_pushpop_end: got %h expected %h", {oBUSY, oOVF, oCOUNT}, {1'b0, 1'b0, 5'd16});
        else passes++;
        checks++;
        if ({oKEYCODE, oASCII, oPRESS, oMOD} !== {8'h08, 8'h65, 1'b0, 8'h00})
            $display("FAIL full_pushpop_head: got %h expected %h", {oKEYCODE, oASCII, oPRESS, oMOD},
                     {8'h08, 8'h65, 1'b0, 8'h00});
        else passes++;
    endtask

    initial begin
        test_reset();
        test_press_shift();
        test_release_rollover();
        test_multi_key();
        test_back_to_back();
        test_overflow();
        test_mid_scan_reset();
        test_full_push_pop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
